// File: rtl/cascade_pkg.sv
// Shared types and default sizing for the cascade stage sequencer.
package cascade_pkg;

  localparam int DEF_W_FEAT_ADDR = 12;
  localparam int DEF_N_STAGES    = 25;
  localparam int DEF_W_STAGE     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_DONE
  } state_t;

endpackage

// File: rtl/feature_range_counter.sv
// Walks one stage's half-open feature range [base, end): holds the current index
// and the stage end, precomputes the last-beat flag, and flags empty ranges.
module feature_range_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] base,
  input  logic [W-1:0] end_in,
  output logic [W-1:0] cur,
  output logic [W-1:0] end_reg,
  output logic         last,
  output logic         empty
);

  // A malformed end (below base) is treated the same as an empty stage.
  assign empty = (end_in <= base);

  // Range registers: load at stage start, step once per accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cur     <= '0;
      end_reg <= '0;
      last    <= 1'b0;
    end else if (load) begin
      cur     <= base;
      end_reg <= end_in;
      last    <= (end_in == base + W'(1));
    end else if (advance) begin
      cur     <= cur + W'(1);
      // The next beat is last when cur+1 == end_reg-1.
      last    <= (cur + W'(2) == end_reg);
    end
  end

endmodule

// File: rtl/cascade_stage_sequencer.sv
// Walks the classifier cascade one stage at a time: fetches each stage's
// cumulative end index, streams its feature indices over valid/ready and
// folds the per-stage verdicts into one detection result per window.
// Optional feature: define CASCADE_EARLY_EXIT_EN to end the window on the
// first failing stage verdict.
module cascade_stage_sequencer
  import cascade_pkg::*;
#(
  parameter int W_FEAT_ADDR = DEF_W_FEAT_ADDR,
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int W_STAGE     = DEF_W_STAGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   detected,
  output logic                   fc_ena,
  output logic [W_STAGE-1:0]     fc_addra,
  input  logic [W_FEAT_ADDR-1:0] fc_doa,
  output logic                   feat_valid,
  input  logic                   feat_ready,
  output logic [W_FEAT_ADDR-1:0] feat_addr,
  output logic [W_STAGE-1:0]     feat_stage,
  output logic                   feat_last,
  input  logic                   stage_res_valid,
  input  logic                   stage_pass
);

  state_t                 state, state_next;
  logic [W_STAGE-1:0]     stage;
  logic [W_FEAT_ADDR-1:0] base;
  logic [W_FEAT_ADDR-1:0] end_reg;
  logic                   all_pass;
  logic                   range_empty;
  logic                   handshake;
  logic                   verdict;
  logic                   last_stage;
  logic                   stop_here;

  assign handshake  = feat_valid & feat_ready;
  assign verdict    = (state == ST_WAIT_RES) & stage_res_valid;
  assign last_stage = (stage == W_STAGE'(N_STAGES - 1));

`ifdef CASCADE_EARLY_EXIT_EN
  assign stop_here = last_stage | ~stage_pass;
`else
  assign stop_here = last_stage;
`endif

  // Stage index drives both the ROM address and the beat's stage tag.
  assign fc_addra   = stage;
  assign feat_stage = stage;

  feature_range_counter #(
    .W(W_FEAT_ADDR)
  ) u_range (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_LOAD),
    .advance(handshake),
    .base   (base),
    .end_in (fc_doa),
    .cur    (feat_addr),
    .end_reg(end_reg),
    .last   (feat_last),
    .empty  (range_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE:     if (start) state_next = ST_FETCH;
      ST_FETCH:    state_next = ST_LOAD;
      ST_LOAD:     state_next = range_empty ? ST_WAIT_RES : ST_ISSUE;
      ST_ISSUE:    if (handshake && feat_last) state_next = ST_WAIT_RES;
      ST_WAIT_RES: if (stage_res_valid) state_next = stop_here ? ST_DONE : ST_FETCH;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Registered outputs and per-window bookkeeping (stage, base, verdict AND).
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset is sampled only on the clock edge, so it lives inside the clocked branch.
    if (rst) begin
      stage      <= '0;
      base       <= '0;
      all_pass   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      detected   <= 1'b0;
      fc_ena     <= 1'b0;
      feat_valid <= 1'b0;
    end else begin
      busy       <= state_next inside {ST_FETCH, ST_LOAD, ST_ISSUE, ST_WAIT_RES};
      done       <= (state_next == ST_DONE);
      fc_ena     <= (state_next == ST_FETCH);
      feat_valid <= (state_next == ST_ISSUE);

      if (state == ST_IDLE && start) begin
        stage    <= '0;
        base     <= '0;
        all_pass <= 1'b1;
        detected <= 1'b0;
      end

      if (verdict) begin
        all_pass <= all_pass & stage_pass;
        base     <= end_reg;
        if (stop_here) detected <= all_pass & stage_pass;
        else           stage    <= stage + W_STAGE'(1);
      end
    end
  end

endmodule
